druaga_sprite_sched: RTL and testbench

//  Per-scanline sprite scheduler ahead of the sprite renderer.
//  - On each LINE_START, scans all sprite-attribute entries for the target line and runs the vertical hit test.
//  - Queues hits in ascending index order; later entries overwrite earlier ones in the line buffer.
//  - Dispatches one render command per hit to the renderer over a valid/ready handshake.
//  - Owns the read port of the sprite attribute RAM during the scan.

---
 rtl/druaga_sprite_pkg.sv | 29 ++
 rtl/sprite_hit_fifo.sv | 59 +++++
 rtl/druaga_sprite_sched.sv | 135 +++++++++++++
 tb/tb_druaga_sprite_sched.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/druaga_sprite_pkg.sv
// Shared constants and types for the per-scanline sprite scheduler.
package druaga_sprite_pkg;

    localparam int NSPR_MAX   = 64;

    localparam int CODE_MSB   = 7;
    localparam int CODE_LSB   = 0;
    localparam int YPOS_MSB   = 15;
    localparam int YPOS_LSB   = 8;
    localparam int ATTR_MSB   = 23;
    localparam int ATTR_LSB   = 16;

    localparam int ATTR_FLIPX = 0;
    localparam int ATTR_FLIPY = 1;
    localparam int ATTR_TALL  = 3;

    localparam logic [8:0] Y_BIAS = 9'h10;

    localparam int HIT_W = 11;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        EVAL,
        DONE
    } sched_state_t;

endpackage

// File: rtl/sprite_hit_fifo.sv
// Synchronous hit queue holding {idx,row}; occupancy counter gives full/empty.
module sprite_hit_fifo #(
    parameter int QDEPTH = 16,
    parameter int W      = 11
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int         AW       = $clog2(QDEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(QDEPTH);

    logic [W-1:0]  mem_q [QDEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   cnt_q;
    logic          push_ok;
    logic          pop_ok;

    // A push into a full queue is only legal when a pop frees a slot on the same edge.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + 1'b1;
            if (pop_ok)  rd_q <= rd_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i) mem_q[wr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_q];
    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/druaga_sprite_sched.sv
// Per-scanline sprite scheduler: scans attribute RAM, hit-tests each entry
// against the target line and dispatches render commands over valid/ready.
module druaga_sprite_sched
    import druaga_sprite_pkg::*;
#(
    parameter int NSPR    = 64,
    parameter int QDEPTH  = 16,
    parameter int RAM_LAT = 1
) (
    input  logic        VCLKx8,
    input  logic        RESET,
    input  logic        LINE_START,
    input  logic [8:0]  VPOSL,
    output logic [5:0]  SPRA_A,
    output logic        SPRA_RD,
    input  logic [23:0] SPRA_D,
    output logic        CMD_VALID,
    input  logic        CMD_READY,
    output logic [5:0]  CMD_IDX,
    output logic [4:0]  CMD_ROW,
    output logic        BUSY,
    output logic        OVERFLOW
);

    localparam logic [5:0] N_LAST    = 6'(NSPR - 1);
    localparam logic [1:0] WAIT_LAST = 2'((RAM_LAT > 1) ? RAM_LAT - 2 : 0);

    sched_state_t state_q, state_d;
    logic [5:0]   n_q, n_d;
    logic [1:0]   wcnt_q, wcnt_d;
    logic [8:0]   vpos_q, vpos_d;
    logic         ovf_q, ovf_d;

    logic [8:0]   y;
    logic         tall;
    logic         hit;
    logic [4:0]   row;
    logic         push;
    logic         pop;
    logic         fifo_full;
    logic         fifo_empty;
    logic [HIT_W-1:0] fifo_dout;
    logic         unused_spra;

    assign unused_spra = ^{SPRA_D[ATTR_MSB:ATTR_LSB+ATTR_TALL+1],
                           SPRA_D[ATTR_LSB+ATTR_TALL-1:ATTR_LSB],
                           SPRA_D[CODE_MSB:CODE_LSB]};

    assign tall = SPRA_D[ATTR_LSB+ATTR_TALL];
    assign y    = {1'b0, SPRA_D[YPOS_MSB:YPOS_LSB]} + Y_BIAS + vpos_q;
    assign hit  = !y[8] && (tall ? (y[7:5] == 3'b111) : (y[7:4] == 4'hF));
    assign row  = y[4:0] & {tall, 4'hF};

    // LINE_START flushes the queue, so neither a push nor a pop may land on that edge.
    assign pop  = CMD_VALID && CMD_READY && !LINE_START;
    assign push = (state_q == EVAL) && hit && !LINE_START && (!fifo_full || pop);

    always_ff @(posedge VCLKx8 or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            n_q     <= '0;
            wcnt_q  <= '0;
            vpos_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            wcnt_q  <= wcnt_d;
            vpos_q  <= vpos_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        wcnt_d  = wcnt_q;
        vpos_d  = vpos_q;
        ovf_d   = ovf_q;
        if (LINE_START) begin
            state_d = ISSUE;
            n_d     = '0;
            wcnt_d  = '0;
            vpos_d  = VPOSL;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                ISSUE: begin
                    wcnt_d  = '0;
                    state_d = (RAM_LAT > 1) ? WAIT : EVAL;
                end
                WAIT: begin
                    if (wcnt_q == WAIT_LAST) state_d = EVAL;
                    else                     wcnt_d  = wcnt_q + 1'b1;
                end
                EVAL: begin
                    if (hit && fifo_full && !pop) ovf_d = 1'b1;
                    if (n_q == N_LAST) begin
                        state_d = DONE;
                    end else begin
                        n_d     = n_q + 1'b1;
                        state_d = ISSUE;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    sprite_hit_fifo #(
        .QDEPTH (QDEPTH),
        .W      (HIT_W)
    ) u_fifo (
        .clk_i   (VCLKx8),
        .rst_i   (RESET),
        .flush_i (LINE_START),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   ({n_q, row}),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign SPRA_A    = n_q;
    assign SPRA_RD   = (state_q == ISSUE);
    assign BUSY      = (state_q == ISSUE) || (state_q == WAIT) || (state_q == EVAL);
    assign OVERFLOW  = ovf_q;
    assign CMD_VALID = !fifo_empty;
    assign CMD_IDX   = CMD_VALID ? fifo_dout[10:5] : '0;
    assign CMD_ROW   = CMD_VALID ? fifo_dout[4:0]  : '0;

endmodule

// File: tb/tb_druaga_sprite_sched.sv
// Directed bench for druaga_sprite_sched: single-hit vector table plus
// multi-cycle sequences for overflow, stall, line restart and async reset.
module tb_druaga_sprite_sched;

    localparam int NSPR    = 64;
    localparam int QDEPTH  = 16;
    localparam int RAM_LAT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        line_start;
    logic [8:0]  vposl;
    logic [5:0]  spra_a;
    logic        spra_rd;
    logic [23:0] spra_d;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [5:0]  cmd_idx;
    logic [4:0]  cmd_row;
    logic        busy;
    logic        overflow;

    logic [23:0] ram [NSPR];

    int checks   = 0;
    int failures = 0;
    int log_idx[$];
    int log_row[$];
    int busy_cnt;
    int stall_err;
    bit hold_v;
    logic [5:0] hold_idx;
    logic [4:0] hold_row;

    always #5 clk = ~clk;

    always @(posedge clk) if (spra_rd) spra_d <= ram[spra_a];

    druaga_sprite_sched #(
        .NSPR    (NSPR),
        .QDEPTH  (QDEPTH),
        .RAM_LAT (RAM_LAT)
    ) dut (
        .VCLKx8     (clk),
        .RESET      (rst),
        .LINE_START (line_start),
        .VPOSL      (vposl),
        .SPRA_A     (spra_a),
        .SPRA_RD    (spra_rd),
        .SPRA_D     (spra_d),
        .CMD_VALID  (cmd_valid),
        .CMD_READY  (cmd_ready),
        .CMD_IDX    (cmd_idx),
        .CMD_ROW    (cmd_row),
        .BUSY       (busy),
        .OVERFLOW   (overflow)
    );

    typedef struct {
        logic [8:0] v;
        logic [7:0] ypos;
        logic       tall;
        int         idx;
        bit         hit;
        int         row;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Background entry that misses for line v: y[7:0] always lands on 0.
    task automatic load_bg(input logic [8:0] v);
        for (int i = 0; i < NSPR; i++) ram[i] = {8'h00, 8'(8'hF0 - v[7:0]), 8'(i)};
    endtask

    task automatic set_entry(input int i, input logic [7:0] ypos, input logic tall);
        ram[i] = {4'h0, tall, 3'b000, ypos, 8'(i)};
    endtask

    task automatic clear_log();
        log_idx.delete();
        log_row.delete();
        busy_cnt  = 0;
        stall_err = 0;
        hold_v    = 1'b0;
    endtask

    task automatic pulse_line(input logic [8:0] v);
        line_start = 1'b1;
        vposl      = v;
        @(negedge clk);
        line_start = 1'b0;
    endtask

    // Called at a negedge; mode 0: ready=1, 1: ready=0, 2: ready toggles.
    task automatic run_cycles(input int n, input int mode);
        for (int c = 0; c < n; c++) begin
            if (hold_v && !(cmd_valid && cmd_idx == hold_idx && cmd_row == hold_row))
                stall_err++;
            case (mode)
                0:       cmd_ready = 1'b1;
                1:       cmd_ready = 1'b0;
                default: cmd_ready = ~cmd_ready;
            endcase
            if (cmd_valid && cmd_ready) begin
                log_idx.push_back(int'(cmd_idx));
                log_row.push_back(int'(cmd_row));
            end
            hold_v   = cmd_valid && !cmd_ready;
            hold_idx = cmd_idx;
            hold_row = cmd_row;
            if (busy) busy_cnt++;
            @(negedge clk);
        end
    endtask

    function automatic int log_at_idx(input int i);
        return (i < log_idx.size()) ? log_idx[i] : -1;
    endfunction

    function automatic int log_at_row(input int i);
        return (i < log_row.size()) ? log_row[i] : -1;
    endfunction

    task automatic run_vec(input int k);
        load_bg(vecs[k].v);
        set_entry(vecs[k].idx, vecs[k].ypos, vecs[k].tall);
        clear_log();
        pulse_line(vecs[k].v);
        run_cycles(140, 0);
        check($sformatf("vec%0d busy_cycles", k), busy_cnt, 128);
        check($sformatf("vec%0d cmd_count", k), log_idx.size(), vecs[k].hit ? 1 : 0);
        check($sformatf("vec%0d overflow", k), overflow, 0);
        if (vecs[k].hit) begin
            check($sformatf("vec%0d idx", k), log_at_idx(0), vecs[k].idx);
            check($sformatf("vec%0d row", k), log_at_row(0), vecs[k].row);
        end
    endtask

    initial begin
        vecs[0]  = '{9'h000, 8'hE5, 1'b0,  5, 1'b1,  5};
        vecs[1]  = '{9'h000, 8'hD3, 1'b1,  9, 1'b1,  3};
        vecs[2]  = '{9'h000, 8'hD3, 1'b0,  9, 1'b0,  0};
        vecs[3]  = '{9'h020, 8'hC0, 1'b0,  0, 1'b1,  0};
        vecs[4]  = '{9'h1FF, 8'hF0, 1'b0, 63, 1'b1, 15};
        vecs[5]  = '{9'h100, 8'hE0, 1'b0, 10, 1'b0,  0};
        vecs[6]  = '{9'h005, 8'hC0, 1'b1, 33, 1'b0,  0};
        vecs[7]  = '{9'h005, 8'hDA, 1'b1, 20, 1'b1, 15};
        vecs[8]  = '{9'h0F0, 8'hFF, 1'b0,  1, 1'b0,  0};
        vecs[9]  = '{9'h1FF, 8'hE6, 1'b0,  2, 1'b1,  5};
        vecs[10] = '{9'h000, 8'hE9, 1'b1, 40, 1'b1, 25};

        rst        = 1'b1;
        line_start = 1'b0;
        vposl      = '0;
        cmd_ready  = 1'b0;
        spra_d     = '0;
        load_bg(9'h000);

        @(negedge clk);
        check("reset_ctrl", {busy, cmd_valid, spra_rd, overflow}, 4'b0000);
        check("reset_spra_a", spra_a, 0);
        check("reset_cmd", {cmd_idx, cmd_row}, 0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[k]) run_vec(k);

        // 20 hits with the renderer stalled: 16 queued, drops from entry 16 on.
        load_bg(9'h000);
        for (int i = 0; i < 20; i++) set_entry(i, 8'hE0 | 8'(i % 16), 1'b0);
        clear_log();
        pulse_line(9'h000);
        run_cycles(33, 1);
        check("ovf_before_17th", overflow, 0);
        check("stalled_head_valid", cmd_valid, 1);
        run_cycles(1, 1);
        check("ovf_after_17th", overflow, 1);
        run_cycles(100, 1);
        check("stalled_head_idx", cmd_idx, 0);
        check("stalled_no_pop", log_idx.size(), 0);
        check("stalled_stable", stall_err, 0);
        run_cycles(40, 0);
        check("drain_count", log_idx.size(), 16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain%0d_idx", i), log_at_idx(i), i);
            check($sformatf("drain%0d_row", i), log_at_row(i), i);
        end
        check("ovf_sticky", overflow, 1);
        check("drain_empty", cmd_valid, 0);

        // Renderer ready toggling during the scan.
        load_bg(9'h000);
        set_entry(2,  8'hE2, 1'b0);
        set_entry(3,  8'hE3, 1'b0);
        set_entry(4,  8'hE4, 1'b0);
        set_entry(30, 8'hEE, 1'b0);
        set_entry(31, 8'hEF, 1'b0);
        set_entry(63, 8'hEF, 1'b0);
        clear_log();
        cmd_ready = 1'b0;
        pulse_line(9'h000);
        run_cycles(150, 2);
        check("toggle_count", log_idx.size(), 6);
        check("toggle_stable", stall_err, 0);
        check("toggle_busy", busy_cnt, 128);
        check("toggle_seq_idx",
              {8'(log_at_idx(0)), 8'(log_at_idx(1)), 8'(log_at_idx(2)), 8'(log_at_idx(3))},
              {8'd2, 8'd3, 8'd4, 8'd30});
        check("toggle_tail_idx", {8'(log_at_idx(4)), 8'(log_at_idx(5))}, {8'd31, 8'd63});
        check("toggle_rows",
              {5'(log_at_row(0)), 5'(log_at_row(1)), 5'(log_at_row(2)),
               5'(log_at_row(3)), 5'(log_at_row(4)), 5'(log_at_row(5))},
              {5'd2, 5'd3, 5'd4, 5'd14, 5'd15, 5'd15});

        // New line mid-scan with a full queue and OVERFLOW set.
        for (int i = 0; i < NSPR; i++) ram[i] = {8'h00, 8'h00, 8'(i)};
        for (int i = 0; i < 17; i++) set_entry(i, 8'hE0 | 8'(i % 16), 1'b0);
        set_entry(40, 8'hD8, 1'b0);
        clear_log();
        pulse_line(9'h000);
        run_cycles(39, 1);
        check("restart_pre_ovf", overflow, 1);
        check("restart_pre_valid", cmd_valid, 1);
        line_start = 1'b1;
        vposl      = 9'h010;
        cmd_ready  = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        check("restart_flushed", cmd_valid, 0);
        check("restart_ovf_clr", overflow, 0);
        check("restart_issue0", {spra_rd, busy, spra_a}, {1'b1, 1'b1, 6'd0});
        clear_log();
        run_cycles(150, 0);
        check("restart_busy", busy_cnt, 128);
        check("restart_count", log_idx.size(), 1);
        check("restart_cmd", {8'(log_at_idx(0)), 8'(log_at_row(0))}, {8'd40, 8'd8});

        // Async reset mid-scan with a command pending.
        load_bg(9'h000);
        set_entry(0, 8'hE0, 1'b0);
        clear_log();
        pulse_line(9'h000);
        run_cycles(20, 1);
        check("rst_pre", {cmd_valid, spra_rd, busy}, 3'b111);
        rst = 1'b1;
        #1;
        check("rst_immediate", {cmd_valid, spra_rd, busy, overflow}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        clear_log();
        run_cycles(30, 0);
        check("rst_idle_busy", busy_cnt, 0);
        check("rst_idle_cmds", log_idx.size(), 0);
        run_vec(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
